// File: rtl/branch_redirect_pc_if.sv
// Bundle carrying the EX redirect inputs, fetch request handshake, status and stats of the PC stage.
// The master modport is the PC stage; the slave modport is the surrounding pipeline (EX, decode, fetch).
interface branch_redirect_pc_if #(
   parameter int XLEN = 64
);
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_imm;
   logic            btype;
   logic            jump;
   logic            jal;
   logic            jalr;
   logic [XLEN-1:0] rs1_data;
   logic            stall;
   logic            if_ready;
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic            flush;
   logic            misalign;
   logic [31:0]     br_taken_cnt;
   logic [31:0]     br_total_cnt;

   modport master (
      input  ex_valid, ex_pc, ex_imm, btype, jump, jal, jalr, rs1_data, stall, if_ready,
      output if_valid, if_pc, flush, misalign, br_taken_cnt, br_total_cnt
   );

   modport slave (
      output ex_valid, ex_pc, ex_imm, btype, jump, jal, jalr, rs1_data, stall, if_ready,
      input  if_valid, if_pc, flush, misalign, br_taken_cnt, br_total_cnt
   );
endinterface

// File: rtl/branch_redirect_pc.sv
// Fetch PC generator with static not-taken prediction; taken branches/jumps redirect fetch and flush IF/ID.
// Optional branch statistics counters are enabled by defining YSYX_22040931_BR_STATS_EN.
module branch_redirect_pc #(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] RESET_PC    = 'h8000_0000,
   parameter int              FLUSH_SLOTS = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   branch_redirect_pc_if.master bus
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_SLOTS - 1);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
   localparam logic [XLEN-1:0] JALR_MASK  = {{(XLEN-1){1'b1}}, 1'b0};

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [2:0]      flush_cnt_q, flush_cnt_d;
   logic            misalign_q, misalign_d;

   logic            in_run;
   logic            redirect;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] target;
   logic            target_misaligned;
   logic            fetch_fire;

   assign in_run            = (state_q == ST_RUN);
   assign redirect          = in_run && bus.ex_valid &&
                              ((bus.btype && bus.jump) || bus.jal || bus.jalr);
   assign jalr_sum          = bus.rs1_data + bus.ex_imm;
   assign target            = bus.jalr ? (jalr_sum & JALR_MASK) : (bus.ex_pc + bus.ex_imm);
   assign target_misaligned = (target[1:0] != 2'b00);
   assign fetch_fire        = in_run && bus.if_ready && !bus.stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC;
         flush_cnt_q <= 3'd0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         flush_cnt_q <= flush_cnt_d;
         misalign_q  <= misalign_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      flush_cnt_d = flush_cnt_q;
      misalign_d  = misalign_q;

      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // A redirect wins over stall and over a same-cycle accepted request; that request is flushed.
            if (redirect) begin
               if (target_misaligned) begin
                  misalign_d = 1'b1;
                  state_d    = ST_HALT;
               end else begin
                  pc_d        = target;
                  flush_cnt_d = FLUSH_INIT;
                  state_d     = ST_FLUSH;
               end
            end else if (fetch_fire) begin
               pc_d = pc_q + PC_STEP;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == 3'd0) begin
               state_d = ST_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   assign bus.if_valid = in_run;
   assign bus.if_pc    = pc_q;
   assign bus.flush    = (state_q == ST_FLUSH);
   assign bus.misalign = misalign_q;

`ifdef YSYX_22040931_BR_STATS_EN
   logic        resolved;
   logic [31:0] taken_cnt_q, taken_cnt_d;
   logic [31:0] total_cnt_q, total_cnt_d;

   assign resolved = in_run && bus.ex_valid && (bus.btype || bus.jal || bus.jalr);

   // Both counters saturate instead of wrapping.
   always_comb begin
      taken_cnt_d = taken_cnt_q;
      total_cnt_d = total_cnt_q;
      if (redirect && (taken_cnt_q != 32'hFFFF_FFFF)) begin
         taken_cnt_d = taken_cnt_q + 32'd1;
      end
      if (resolved && (total_cnt_q != 32'hFFFF_FFFF)) begin
         total_cnt_d = total_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_cnt_q <= 32'd0;
         total_cnt_q <= 32'd0;
      end else begin
         taken_cnt_q <= taken_cnt_d;
         total_cnt_q <= total_cnt_d;
      end
   end

   assign bus.br_taken_cnt = taken_cnt_q;
   assign bus.br_total_cnt = total_cnt_q;
`else
   assign bus.br_taken_cnt = 32'h0;
   assign bus.br_total_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_branch_redirect_pc.sv
// Directed plus random bench for branch_redirect_pc against a cycle-level reference model.
module tb_branch_redirect_pc;
   localparam logic [63:0] RST_PC = 64'h8000_0000;
   localparam int          SLOTS  = 2;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   branch_redirect_pc_if #(.XLEN(64)) bus();

   branch_redirect_pc #(
      .XLEN(64),
      .RESET_PC(RST_PC),
      .FLUSH_SLOTS(SLOTS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: booting / flush cycles remaining / halted, plus PC and stats.
   logic [63:0] m_pc;
   bit          m_boot;
   int          m_flush_left;
   bit          m_halt;
   bit          m_mis;
   logic [31:0] m_taken;
   logic [31:0] m_total;

   function automatic void model_reset();
      m_pc = RST_PC; m_boot = 1; m_flush_left = 0; m_halt = 0; m_mis = 0;
      m_taken = 0; m_total = 0;
   endfunction

   function automatic void model_clock();
      logic [63:0] tgt;
      bit          taken;
      if (m_boot) begin
         m_boot = 0;
      end else if (m_flush_left > 0) begin
         m_flush_left = m_flush_left - 1;
      end else if (!m_halt) begin
         if (bus.ex_valid && (bus.btype || bus.jal || bus.jalr) && m_total != 32'hFFFF_FFFF)
            m_total = m_total + 1;
         taken = bus.ex_valid && ((bus.btype && bus.jump) || bus.jal || bus.jalr);
         if (taken) begin
            if (m_taken != 32'hFFFF_FFFF) m_taken = m_taken + 1;
            if (bus.jalr) tgt = (bus.rs1_data + bus.ex_imm) & ~64'd1;
            else          tgt = bus.ex_pc + bus.ex_imm;
            if (tgt % 4 != 0) begin
               m_halt = 1; m_mis = 1;
            end else begin
               m_pc = tgt; m_flush_left = SLOTS;
            end
         end else if (bus.if_ready && !bus.stall) begin
            m_pc = m_pc + 4;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] et, eo;
      chk("if_valid", 64'(bus.if_valid), 64'(!m_boot && !m_halt && m_flush_left == 0));
      chk("if_pc", bus.if_pc, m_pc);
      chk("flush", 64'(bus.flush), 64'(m_flush_left > 0));
      chk("misalign", 64'(bus.misalign), 64'(m_mis));
`ifdef YSYX_22040931_BR_STATS_EN
      et = m_taken; eo = m_total;
`else
      et = 0; eo = 0;
`endif
      chk("br_taken_cnt", 64'(bus.br_taken_cnt), 64'(et));
      chk("br_total_cnt", 64'(bus.br_total_cnt), 64'(eo));
   endtask

   task automatic step();
      check_all();
      @(posedge clk);
      if (rst_n) model_clock();
      @(negedge clk);
   endtask

   task automatic clear_ex();
      bus.ex_valid = 0; bus.btype = 0; bus.jump = 0; bus.jal = 0; bus.jalr = 0;
      bus.ex_pc = 0; bus.ex_imm = 0; bus.rs1_data = 0;
   endtask

   task automatic set_ex(input bit bt, input bit jp, input bit jl, input bit jr,
                         input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] rs1);
      bus.ex_valid = 1; bus.btype = bt; bus.jump = jp; bus.jal = jl; bus.jalr = jr;
      bus.ex_pc = pc; bus.ex_imm = imm; bus.rs1_data = rs1;
   endtask

   // Single-cycle control-flow op followed by idle EX inputs.
   task automatic fire(input bit bt, input bit jp, input bit jl, input bit jr,
                       input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] rs1);
      set_ex(bt, jp, jl, jr, pc, imm, rs1);
      step();
      clear_ex();
   endtask

   task automatic do_reset();
      rst_n = 0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      logic [31:0] exp_cnt;
      checks = 0; errors = 0;
      rst_n = 1; bus.stall = 0; bus.if_ready = 1;
      clear_ex();
      model_reset();
      @(negedge clk);
      do_reset();

      // Boot then sequential fetch.
      chk("boot_valid", 64'(bus.if_valid), 64'd0);
      step();
      chk("pc0", bus.if_pc, 64'h8000_0000);
      step();
      chk("pc1", bus.if_pc, 64'h8000_0004);
      step();
      chk("pc2", bus.if_pc, 64'h8000_0008);

      // Fetch back-pressure holds the request.
      bus.if_ready = 0;
      repeat (3) step();
      chk("hold_pc", bus.if_pc, 64'h8000_0008);
      chk("hold_valid", 64'(bus.if_valid), 64'd1);
      bus.if_ready = 1;
      step();
      chk("resume_pc", bus.if_pc, 64'h8000_000C);

      // Taken beq: two flush cycles then restart at target.
      fire(1, 1, 0, 0, 64'h8000_0010, -64'sd16, 0);
      chk("beq_flush0", 64'(bus.flush), 64'd1);
      step();
      chk("beq_flush1", 64'(bus.flush), 64'd1);
      step();
      chk("beq_done", 64'(bus.flush), 64'd0);
      chk("beq_target", bus.if_pc, 64'h8000_0000);

      // Not-taken branch: plain sequential advance.
      fire(1, 0, 0, 0, 64'h8000_0010, 64'h40, 0);
      chk("nt_noflush", 64'(bus.flush), 64'd0);
      chk("nt_pc", bus.if_pc, 64'h8000_0004);

      // Stall freezes PC; jal still redirects.
      bus.stall = 1;
      step(); step();
      chk("stall_pc", bus.if_pc, 64'h8000_0004);
      fire(0, 0, 1, 0, 64'h8000_0100, 64'h20, 0);
      bus.stall = 0;
      step(); step();
      chk("stall_jal", bus.if_pc, 64'h8000_0120);

      // Sequential wrap from the top of the address space.
      fire(0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'hC, 0);
      step(); step();
      chk("wrap_top", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      step();
      chk("wrap_zero", bus.if_pc, 64'h0);

      // Reset in the middle of a flush.
      fire(1, 1, 0, 0, 64'h100, 64'h10, 0);
      chk("midflush", 64'(bus.flush), 64'd1);
      do_reset();
      chk("rst_flush", 64'(bus.flush), 64'd0);
      chk("rst_pc", bus.if_pc, RST_PC);

      // Stats: 3 branches (2 taken) + 1 jal.
      step();
      fire(1, 1, 0, 0, 64'h8000_0000, 64'h8, 0);
      step(); step();
      fire(1, 0, 0, 0, 64'h8000_0008, 64'h8, 0);
      fire(1, 1, 0, 0, 64'h8000_000C, 64'h10, 0);
      step(); step();
      fire(0, 0, 1, 0, 64'h8000_001C, 64'h100, 0);
      step(); step();
`ifdef YSYX_22040931_BR_STATS_EN
      exp_cnt = 32'd4;
`else
      exp_cnt = 32'd0;
`endif
      chk("stats_total", 64'(bus.br_total_cnt), 64'(exp_cnt));
`ifdef YSYX_22040931_BR_STATS_EN
      exp_cnt = 32'd3;
`endif
      chk("stats_taken", 64'(bus.br_taken_cnt), 64'(exp_cnt));

      // Misaligned jalr halts until reset.
      fire(0, 0, 0, 1, 64'h8000_0200, 64'h2, 64'h8000_1001);
      chk("mis_flag", 64'(bus.misalign), 64'd1);
      chk("mis_valid", 64'(bus.if_valid), 64'd0);
      repeat (3) step();
      chk("halt_valid", 64'(bus.if_valid), 64'd0);
      do_reset();
      chk("mis_cleared", 64'(bus.misalign), 64'd0);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         bus.if_ready = ($urandom_range(0, 3) != 0);
         bus.stall    = ($urandom_range(0, 7) == 0);
         clear_ex();
         if ($urandom_range(0, 3) == 0) begin
            logic [63:0] imm;
            int          kind;
            imm  = 64'($signed($urandom_range(0, 127)) - 64) * 4;
            if ($urandom_range(0, 15) == 0) imm = imm + 2;
            kind = $urandom_range(0, 3);
            set_ex(kind <= 1, $urandom_range(0, 1) == 1, kind == 2, kind == 3,
                   {$urandom, $urandom} & ~64'd3, imm,
                   ({$urandom, $urandom} & ~64'd3) | 64'($urandom_range(0, 1)));
         end
         if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
            clear_ex();
            do_reset();
         end else begin
            step();
         end
      end
      clear_ex();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
